// File: rtl/i2s_audio_in.sv
`default_nettype none
// ============================================================================
// Module      : i2s_audio_in
// Description : I2S stereo receiver. Oversamples bclk/lrclk/sdata on the
//               system clock, aligns to word-select boundaries, checks slot
//               lengths and presents left/right sample pairs with a valid pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_audio_in #(
    parameter int DATA_W      = 16,
    parameter int SLOT_W      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic              i_bclk,
    input  logic              i_lrclk,
    input  logic              i_sdata,
    output logic [DATA_W-1:0] o_left,
    output logic [DATA_W-1:0] o_right,
    output logic              o_valid,
    output logic              o_locked,
    output logic              o_frame_err
);

    // Counter must hold SLOT_W+1 (saturation value).
    localparam int c_CNT_W = $clog2(SLOT_W + 2);
    localparam logic [c_CNT_W-1:0] c_SAT      = c_CNT_W'(SLOT_W + 1);
    localparam logic [c_CNT_W-1:0] c_DATA_LEN = c_CNT_W'(DATA_W);
    localparam logic [c_CNT_W-1:0] c_SLOT_LEN = c_CNT_W'(SLOT_W);

    localparam logic [1:0] c_SEEK = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_ERR  = 2'd2;

    logic [SYNC_STAGES-1:0] r_bclk_sync;
    logic [SYNC_STAGES-1:0] r_ws_sync;
    logic [SYNC_STAGES-1:0] r_sd_sync;
    logic                   r_bclk_prev;

    logic [1:0]         r_state;
    logic               r_ws_d;
    logic [c_CNT_W-1:0] r_bit_cnt;
    logic [DATA_W-1:0]  r_shift;
    logic [DATA_W-1:0]  r_left_buf;
    logic               r_left_ok;

    logic               w_bclk_s;
    logic               w_ws;
    logic               w_sd;
    logic               w_edge;
    logic               w_boundary;
    logic [c_CNT_W-1:0] w_len;
    logic               w_len_ok;
    logic [c_CNT_W-1:0] w_cnt_inc;
    logic [DATA_W-1:0]  w_shift_next;

    // Multi-stage synchronizers for the three asynchronous pins plus bclk history.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bclk_sync <= '0;
            r_ws_sync   <= '0;
            r_sd_sync   <= '0;
            r_bclk_prev <= 1'b0;
        end else begin
            r_bclk_sync <= {r_bclk_sync[SYNC_STAGES-2:0], i_bclk};
            r_ws_sync   <= {r_ws_sync[SYNC_STAGES-2:0], i_lrclk};
            r_sd_sync   <= {r_sd_sync[SYNC_STAGES-2:0], i_sdata};
            r_bclk_prev <= w_bclk_s;
        end
    end

    // Edge detection, slot-length evaluation and next shift-register value.
    always_comb begin
        w_bclk_s     = r_bclk_sync[SYNC_STAGES-1];
        w_ws         = r_ws_sync[SYNC_STAGES-1];
        w_sd         = r_sd_sync[SYNC_STAGES-1];
        w_edge       = w_bclk_s & ~r_bclk_prev;
        w_boundary   = (w_ws != r_ws_d);
        // The current edge counts as part of the slot, hence +1.
        w_len        = r_bit_cnt + c_CNT_W'(1);
        w_len_ok     = (w_len >= c_DATA_LEN) && (w_len <= c_SLOT_LEN);
        w_cnt_inc    = (r_bit_cnt == c_SAT) ? r_bit_cnt : w_len;
        // Bits beyond DATA_W are dropped so long slots truncate to the MSBs.
        w_shift_next = (r_bit_cnt < c_DATA_LEN) ? {r_shift[DATA_W-2:0], w_sd} : r_shift;
    end

    // Framing FSM: seek a boundary, capture slots, flag bad slot lengths.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_SEEK;
            r_ws_d      <= 1'b0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_left_buf  <= '0;
            r_left_ok   <= 1'b0;
            o_left      <= '0;
            o_right     <= '0;
            o_valid     <= 1'b0;
            o_locked    <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            // Word-select history tracks every edge so re-enabling sees no false boundary.
            if (w_edge) begin
                r_ws_d <= w_ws;
            end
            if (!i_en) begin
                r_state   <= c_SEEK;
                r_bit_cnt <= '0;
                r_shift   <= '0;
                r_left_ok <= 1'b0;
                o_locked  <= 1'b0;
            end else begin
                case (r_state)
                    c_SEEK: begin
                        if (w_edge && w_boundary) begin
                            r_state   <= c_RUN;
                            r_bit_cnt <= '0;
                            r_shift   <= '0;
                            r_left_ok <= 1'b0;
                        end
                    end
                    c_RUN: begin
                        if (w_edge) begin
                            if (w_boundary) begin
                                r_bit_cnt <= '0;
                                r_shift   <= '0;
                                if (w_len_ok) begin
                                    o_locked <= 1'b1;
                                    if (!r_ws_d) begin
                                        r_left_buf <= w_shift_next;
                                        r_left_ok  <= 1'b1;
                                    end else begin
                                        // A right slot only publishes when its left partner was good.
                                        r_left_ok <= 1'b0;
                                        if (r_left_ok) begin
                                            o_left  <= r_left_buf;
                                            o_right <= w_shift_next;
                                            o_valid <= 1'b1;
                                        end
                                    end
                                end else begin
                                    r_state     <= c_ERR;
                                    r_left_ok   <= 1'b0;
                                    o_locked    <= 1'b0;
                                    o_frame_err <= 1'b1;
                                end
                            end else begin
                                r_shift   <= w_shift_next;
                                r_bit_cnt <= w_cnt_inc;
                                // Overlong slot aborts immediately instead of waiting for lrclk.
                                if (w_cnt_inc == c_SAT) begin
                                    r_state     <= c_ERR;
                                    r_left_ok   <= 1'b0;
                                    o_locked    <= 1'b0;
                                    o_frame_err <= 1'b1;
                                end
                            end
                        end
                    end
                    c_ERR: begin
                        r_state   <= c_SEEK;
                        r_bit_cnt <= '0;
                        r_shift   <= '0;
                    end
                    default: begin
                        r_state <= c_SEEK;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
